elevator_scan_controller: RTL and testbench

Parametrised multi-floor elevator controller using SCAN (collective) scheduling. It latches hall/car calls for `NUM_FLOORS` floors into a pending vector and travels in one direction, serving every pending floor on the way before reversing. Each stop runs a timed door-open dwell, and travel between adjacent floors takes a fixed cycle count. It sits between the button inputs and the 7-segment floor display, and its `current_floor` output drives the existing display decoder.

---
 rtl/elevator_pkg.sv | 27 ++
 rtl/elevator_scan_controller_floor_request_scan.sv | 35 +++
 rtl/elevator_scan_controller.sv | 182 ++++++++++++++++++
 tb/tb_elevator_scan_controller.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared definitions for the SCAN elevator controller.
//   state_e          : controller states (IDLE, MOVE, DOOR)
//   DIR_UP/DIR_DOWN  : encoding of the dir_up output
//   FLOOR_LOWEST     : lowest legal floor index, used for the downward range check
//   timer_width()    : width of the shared MOVE/DOOR timer
package elevator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MOVE = 2'd1,
        ST_DOOR = 2'd2
    } state_e;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int unsigned FLOOR_LOWEST = 0;

    // Timer counts 0..max(travel, door)-1; never narrower than one bit.
    function automatic int unsigned timer_width(input int unsigned travel_cycles,
                                                input int unsigned door_cycles);
        int unsigned longest;
        longest = (travel_cycles > door_cycles) ? travel_cycles : door_cycles;
        return (longest > 1) ? $clog2(longest) : 1;
    endfunction

endpackage

// File: rtl/elevator_scan_controller_floor_request_scan.sv
// Combinational scan of the pending-call vector relative to one floor.
//   pending_i   : latched calls, one bit per floor
//   floor_i     : reference floor
//   any_above_o : some call pending strictly above floor_i
//   any_below_o : some call pending strictly below floor_i
//   here_o      : call pending at floor_i
module floor_request_scan
    import elevator_pkg::*;
#(
    parameter int unsigned NUM_FLOORS = 10,
    parameter int unsigned FLOOR_W    = 4
) (
    input  logic [NUM_FLOORS-1:0] pending_i,
    input  logic [FLOOR_W-1:0]    floor_i,
    output logic                  any_above_o,
    output logic                  any_below_o,
    output logic                  here_o
);

    // One spare bit so the one-hot of the top floor never overflows the mask math.
    localparam int unsigned VEC_W = NUM_FLOORS + 1;

    logic [VEC_W-1:0] pend_x;
    logic [VEC_W-1:0] sel;
    logic [VEC_W-1:0] below_mask;

    assign pend_x     = {1'b0, pending_i};
    assign sel        = VEC_W'(1) << floor_i;
    assign below_mask = sel - VEC_W'(1);

    assign here_o      = |(pend_x & sel);
    assign any_below_o = |(pend_x & below_mask);
    assign any_above_o = |(pend_x & ~(below_mask | sel));

endmodule

// File: rtl/elevator_scan_controller.sv
// SCAN (collective) elevator controller: latches floor calls, sweeps in one
// direction serving every pending floor, reverses only when nothing remains ahead.
//   clk, reset    : clock, asynchronous active-high reset
//   call_in       : per-floor call requests, OR-latched into pending
//   current_floor : floor the car is at or last passed
//   dir_up        : travel/preference direction (1 = up)
//   moving        : car between floors
//   door_open     : door dwell in progress
//   arrived       : one-cycle pulse on each floor change
//   pending       : latched, unserved calls
module elevator_scan_controller
    import elevator_pkg::*;
#(
    parameter int unsigned NUM_FLOORS    = 10,
    parameter int unsigned FLOOR_W       = 4,
    parameter int unsigned TRAVEL_CYCLES = 16,
    parameter int unsigned DOOR_CYCLES   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] call_in,
    output logic [FLOOR_W-1:0]    current_floor,
    output logic                  dir_up,
    output logic                  moving,
    output logic                  door_open,
    output logic                  arrived,
    output logic [NUM_FLOORS-1:0] pending
);

    localparam int unsigned TIMER_W = timer_width(TRAVEL_CYCLES, DOOR_CYCLES);
    localparam logic [TIMER_W-1:0] TRAVEL_LAST  = TIMER_W'(TRAVEL_CYCLES - 1);
    localparam logic [TIMER_W-1:0] DOOR_LAST    = TIMER_W'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR    = FLOOR_W'(NUM_FLOORS - 1);
    localparam logic [FLOOR_W-1:0] BOTTOM_FLOOR = FLOOR_W'(FLOOR_LOWEST);

    state_e                  state_q, state_d;
    logic [FLOOR_W-1:0]      floor_q, floor_d;
    logic                    dir_q, dir_d;
    logic [TIMER_W-1:0]      timer_q, timer_d;
    logic [NUM_FLOORS-1:0]   pending_q, pending_d;
    logic                    arrived_q, arrived_d;
    logic                    moving_q, door_q;

    logic                    any_above, any_below, here;
    logic                    next_above, next_below, next_here;
    logic [FLOOR_W-1:0]      floor_step;
    logic [NUM_FLOORS-1:0]   cur_onehot;
    logic                    call_here;
    logic                    enter_door;

    assign floor_step = (dir_q == DIR_UP) ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
    assign cur_onehot = NUM_FLOORS'(1) << floor_q;
    assign call_here  = |(call_in & cur_onehot);

    // Calls relative to the floor the car is at now.
    floor_request_scan #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_scan_cur (
        .pending_i   (pending_q),
        .floor_i     (floor_q),
        .any_above_o (any_above),
        .any_below_o (any_below),
        .here_o      (here)
    );

    // Calls relative to the floor the car is about to step onto.
    floor_request_scan #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_scan_next (
        .pending_i   (pending_q),
        .floor_i     (floor_step),
        .any_above_o (next_above),
        .any_below_o (next_below),
        .here_o      (next_here)
    );

    // Next-state, timer and call-latch logic.
    always_comb begin
        state_d    = state_q;
        floor_d    = floor_q;
        dir_d      = dir_q;
        timer_d    = timer_q;
        arrived_d  = 1'b0;
        pending_d  = pending_q | call_in;
        enter_door = 1'b0;

        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (here) begin
                    enter_door = 1'b1;
                end else if (any_above && (dir_q == DIR_UP || !any_below)) begin
                    state_d = ST_MOVE;
                    dir_d   = DIR_UP;
                end else if (any_below) begin
                    state_d = ST_MOVE;
                    dir_d   = DIR_DOWN;
                end
            end

            ST_MOVE: begin
                if (timer_q == TRAVEL_LAST) begin
                    timer_d = '0;
                    // Stepping past either end is impossible by construction; park instead.
                    if ((dir_q == DIR_UP && floor_q == TOP_FLOOR) ||
                        (dir_q == DIR_DOWN && floor_q == BOTTOM_FLOOR)) begin
                        state_d = ST_IDLE;
                    end else begin
                        floor_d   = floor_step;
                        arrived_d = 1'b1;
                        if (next_here) begin
                            enter_door = 1'b1;
                        end else if ((dir_q == DIR_UP) ? next_above : next_below) begin
                            state_d = ST_MOVE;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end

            ST_DOOR: begin
                // A call for this floor holds the door rather than being queued.
                pending_d = pending_q | (call_in & ~cur_onehot);
                if (call_here) begin
                    timer_d = '0;
                end else if (timer_q == DOOR_LAST) begin
                    timer_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase

        // Serving a floor clears its call, overriding a same-cycle request.
        if (enter_door) begin
            state_d   = ST_DOOR;
            timer_d   = '0;
            pending_d = pending_d & ~(NUM_FLOORS'(1) << floor_d);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            floor_q   <= '0;
            dir_q     <= DIR_UP;
            timer_q   <= '0;
            pending_q <= '0;
            arrived_q <= 1'b0;
            moving_q  <= 1'b0;
            door_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            floor_q   <= floor_d;
            dir_q     <= dir_d;
            timer_q   <= timer_d;
            pending_q <= pending_d;
            arrived_q <= arrived_d;
            moving_q  <= (state_d == ST_MOVE);
            door_q    <= (state_d == ST_DOOR);
        end
    end

    assign current_floor = floor_q;
    assign dir_up        = dir_q;
    assign moving        = moving_q;
    assign door_open     = door_q;
    assign arrived       = arrived_q;
    assign pending       = pending_q;

endmodule

// File: tb/tb_elevator_scan_controller.sv
// Testbench for elevator_scan_controller: directed scenarios plus random calls,
// checked against a behavioural car model through an event scoreboard.
module tb_elevator_scan_controller;

    localparam int NF = 10;
    localparam int FW = 4;
    localparam int TC = 4;
    localparam int DC = 3;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic [NF-1:0] call_in = '0;
    logic [FW-1:0] current_floor;
    logic          dir_up, moving, door_open, arrived;
    logic [NF-1:0] pending;

    elevator_scan_controller #(
        .NUM_FLOORS    (NF),
        .FLOOR_W       (FW),
        .TRAVEL_CYCLES (TC),
        .DOOR_CYCLES   (DC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .call_in       (call_in),
        .current_floor (current_floor),
        .dir_up        (dir_up),
        .moving        (moving),
        .door_open     (door_open),
        .arrived       (arrived),
        .pending       (pending)
    );

    initial forever #5 clk = ~clk;

    // Expected observable events: kind 0 = arrival at floor, kind 1 = door opens at floor.
    typedef struct {
        int kind;
        int floor;
        int cyc;
    } ev_t;

    ev_t exp_q[$];
    int  rd_idx = 0;
    int  n_tests = 0;
    int  n_fail = 0;
    int  arr_cnt = 0;
    int  door_log[$];
    bit  door_prev = 1'b0;

    // Behavioural car: position, direction, activity (0 idle, 1 travelling, 2 door), countdown.
    int  m_pos = 0;
    bit  m_up = 1'b1;
    int  m_mode = 0;
    int  m_left = 0;
    bit  m_arr = 1'b0;
    bit  m_req[NF];
    int  m_cyc = 0;

    function automatic void chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic [NF-1:0] fmask(input int f);
        return NF'(1) << f;
    endfunction

    function automatic bit m_any(input int lo, input int hi);
        for (int i = lo; i <= hi; i++)
            if (i >= 0 && i < NF && m_req[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_pend_vec();
        int v = 0;
        for (int i = 0; i < NF; i++) if (m_req[i]) v |= (1 << i);
        return v;
    endfunction

    task automatic model_step(input logic [NF-1:0] calls);
        int pos0  = m_pos;
        bit door0 = (m_mode == 2);
        bit enter = 1'b0;
        bit above = m_any(m_pos + 1, NF - 1);
        bit below = m_any(0, m_pos - 1);
        int np;
        m_cyc++;
        m_arr = 1'b0;
        case (m_mode)
            0: begin
                if (m_req[m_pos]) enter = 1'b1;
                else if (above && (m_up || !below)) begin m_up = 1'b1; m_mode = 1; m_left = TC; end
                else if (below) begin m_up = 1'b0; m_mode = 1; m_left = TC; end
            end
            1: begin
                m_left--;
                if (m_left == 0) begin
                    np = m_up ? m_pos + 1 : m_pos - 1;
                    if (np < 0 || np >= NF) m_mode = 0;
                    else begin
                        m_pos = np;
                        m_arr = 1'b1;
                        exp_q.push_back('{0, m_pos, m_cyc});
                        m_left = TC;
                        if (m_req[m_pos]) enter = 1'b1;
                        else if (!(m_up ? m_any(m_pos + 1, NF - 1) : m_any(0, m_pos - 1))) m_mode = 0;
                    end
                end
            end
            default: begin
                if (calls[m_pos]) m_left = DC;
                else begin
                    m_left--;
                    if (m_left == 0) m_mode = 0;
                end
            end
        endcase
        for (int i = 0; i < NF; i++)
            if (calls[i] && !(door0 && i == pos0)) m_req[i] = 1'b1;
        if (enter) begin
            m_mode = 2;
            m_left = DC;
            m_req[m_pos] = 1'b0;
            exp_q.push_back('{1, m_pos, m_cyc});
        end
    endtask

    // Reference model advances on every edge; reset is asynchronous like the DUT.
    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            m_pos = 0; m_up = 1'b1; m_mode = 0; m_left = 0; m_arr = 1'b0;
            for (int i = 0; i < NF; i++) m_req[i] = 1'b0;
        end else begin
            model_step(call_in);
        end
    end

    task automatic take_event(input int kind);
        ev_t e;
        bit  avail = (rd_idx < exp_q.size());
        chk("event_available", int'(avail), 1);
        if (avail) begin
            e = exp_q[rd_idx];
            rd_idx++;
            chk("event_kind", kind, e.kind);
            chk("event_floor", int'(current_floor), e.floor);
            chk("event_cycle", m_cyc, e.cyc);
        end
    endtask

    // Monitor: sample DUT mid-cycle, compare state and pop events as they appear.
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            chk("floor", int'(current_floor), m_pos);
            chk("dir_up", int'(dir_up), int'(m_up));
            chk("moving", int'(moving), int'(m_mode == 1));
            chk("door_open", int'(door_open), int'(m_mode == 2));
            chk("arrived", int'(arrived), int'(m_arr));
            chk("pending", int'(pending), m_pend_vec());
            if (arrived) begin
                arr_cnt++;
                take_event(0);
            end
            if (door_open && !door_prev) begin
                door_log.push_back(int'(current_floor));
                take_event(1);
            end
        end
        door_prev = door_open;
    end

    task automatic pulse(input logic [NF-1:0] m);
        @(negedge clk);
        call_in = m;
        @(negedge clk);
        call_in = '0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            ok = (m_mode == 0) && !m_any(0, NF - 1);
        end
        chk({"timeout_", name}, int'(ok), 1);
    endtask

    task automatic wait_for(input int mode, input int pos, input int budget, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            ok = (m_mode == mode) && (m_pos == pos);
        end
        chk({"timeout_", name}, int'(ok), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d checks so far", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int dcnt, mv, p5, a0, d0, hold;

        repeat (2) @(negedge clk);
        chk("rst_floor", int'(current_floor), 0);
        chk("rst_dir", int'(dir_up), 1);
        chk("rst_moving", int'(moving), 0);
        chk("rst_door", int'(door_open), 0);
        chk("rst_arrived", int'(arrived), 0);
        chk("rst_pending", int'(pending), 0);
        reset = 1'b0;

        // Call at the current floor: door only, no travel.
        pulse(fmask(0));
        dcnt = 0; mv = 0;
        repeat (12) begin
            @(negedge clk);
            dcnt += int'(door_open);
            mv |= int'(moving);
        end
        chk("s2_door_cycles", dcnt, 3);
        chk("s2_no_motion", mv, 0);
        chk("s2_floor", int'(current_floor), 0);

        // Single call three floors up.
        a0 = arr_cnt;
        pulse(fmask(3));
        wait_idle(200, "s1");
        chk("s1_arrivals", arr_cnt - a0, 3);
        chk("s1_floor", int'(current_floor), 3);
        chk("s1_pending", int'(pending), 0);

        // Intermediate pickup on the way up, passed floor served after reversal.
        pulse(fmask(0));
        wait_idle(200, "s3_home");
        pulse(fmask(6));
        wait_for(1, 2, 200, "s3_at2");
        d0 = door_log.size();
        pulse(fmask(4) | fmask(1));
        wait_idle(400, "s3");
        chk("s3_stop_count", door_log.size() - d0, 3);
        if (door_log.size() - d0 == 3) begin
            chk("s3_stop0", door_log[d0], 4);
            chk("s3_stop1", door_log[d0 + 1], 6);
            chk("s3_stop2", door_log[d0 + 2], 1);
        end
        chk("s3_pending", int'(pending), 0);

        // Door held open by a repeat call on its second cycle.
        pulse(fmask(5));
        wait_for(2, 5, 200, "s4_door");
        dcnt = int'(door_open);
        p5 = 0;
        @(negedge clk);
        dcnt += int'(door_open);
        call_in = fmask(5);
        @(negedge clk);
        call_in = '0;
        dcnt += int'(door_open);
        p5 |= int'(pending[5]);
        repeat (8) begin
            @(negedge clk);
            dcnt += int'(door_open);
            p5 |= int'(pending[5]);
        end
        chk("s4_door_cycles", dcnt, 5);
        chk("s4_pending5", p5, 0);

        // Idle facing down with calls on both sides: down first.
        pulse(fmask(7));
        wait_idle(200, "s5_up");
        pulse(fmask(5));
        wait_idle(200, "s5_down");
        chk("s5_dir", int'(dir_up), 0);
        chk("s5_floor", int'(current_floor), 5);
        d0 = door_log.size();
        pulse(fmask(8) | fmask(2));
        wait_idle(400, "s5");
        chk("s5_stop_count", door_log.size() - d0, 2);
        if (door_log.size() - d0 == 2) begin
            chk("s5_stop0", door_log[d0], 2);
            chk("s5_stop1", door_log[d0 + 1], 8);
        end

        // Asynchronous reset while travelling between floors 3 and 4.
        pulse(fmask(1));
        wait_idle(200, "s6_home");
        pulse(fmask(7) | fmask(9));
        wait_for(1, 3, 200, "s6_at3");
        chk("s6_events_drained", rd_idx, exp_q.size());
        #2 reset = 1'b1;
        #1;
        chk("s6_floor", int'(current_floor), 0);
        chk("s6_dir", int'(dir_up), 1);
        chk("s6_moving", int'(moving), 0);
        chk("s6_door", int'(door_open), 0);
        chk("s6_arrived", int'(arrived), 0);
        chk("s6_pending", int'(pending), 0);
        @(posedge clk);
        #2 reset = 1'b0;

        // Random calls, occasionally held for a few cycles or doubled up.
        hold = 0;
        repeat (1500) begin
            @(negedge clk);
            if (hold > 0) begin
                hold--;
            end else begin
                call_in = '0;
                if ($urandom_range(5) == 0) begin
                    call_in = fmask(int'($urandom_range(NF - 1)));
                    if ($urandom_range(3) == 0) call_in |= fmask(int'($urandom_range(NF - 1)));
                    hold = int'($urandom_range(3));
                end
            end
        end
        @(negedge clk);
        call_in = '0;
        wait_idle(2000, "random_drain");
        chk("final_pending", int'(pending), 0);
        chk("final_events_drained", rd_idx, exp_q.size());

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
